sort_pass_sched: RTL and testbench
==================================

// Module: sort_pass_sched
// PURPOSE
//  Sequencer for a folded bitonic sorter built around one compare-exchange stage (group_pipline).
//  Accepts one DATA_CNT-element frame, then issues all LOG2_CNT*(LOG2_CNT+1)/2 passes (phase,step) through the stage.
//  Strobes write-back of each pass result into the working register, then presents the sorted frame downstream.
//  Control only: it drives datapath mux/enable/index lines and owns no frame data.
// PARAMETERS
//  DATA_CNT   1024  elements per frame; power of 2, >=4
//  LOG2_CNT   10    log2(DATA_CNT)
//  STAGE_LAT  1     register latency of compare stage, 1..15 cycles
//  PASS_W     6     width of pass counter; >= clog2(LOG2_CNT*(LOG2_CNT+1)/2+1)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         async reset, active-high
//  flush      in   1         sync abort, drops frame in flight
//  in_valid   in   1         upstream frame valid
//  in_ready   out  1         sched can accept a frame
//  out_valid  out  1         working register holds sorted frame
//  out_ready  in   1         downstream accepts frame
//  dp_load    out  1         1-cycle pulse: working reg <= input frame
//  dp_en      out  1         1-cycle pulse: launch pass into stage
//  dp_wb      out  1         1-cycle pulse: working reg <= stage output
//  dp_phase   out  LOG2_CNT  bitonic phase p of current pass, binary
//  dp_step    out  LOG2_CNT  step s of current pass (s<=p), binary
//  busy       out  1         frame accepted and not yet delivered
//  pass_cnt   out  PASS_W    passes written back for current frame
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including in_ready. in_ready rises in first cycle after rst falls.
//  States: IDLE -> ISSUE -> WAIT -> (ISSUE | OUT) -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready => dp_load=1 same cycle (comb), busy=1, p=s=0, pass_cnt=0 -> ISSUE.
//  ISSUE: dp_en=1 for exactly 1 cycle; dp_phase/dp_step stable from ISSUE through WAIT -> WAIT.
//  WAIT: lasts STAGE_LAT cycles; dp_wb=1 in the last one; pass_cnt+1 on that edge.
//  Index advance on dp_wb: s>0 => s-1; s==0 & p<LOG2_CNT-1 => p+1, s=p+1 -> ISSUE.
//  Last pass (p=LOG2_CNT-1, s=0) -> OUT.
//  Accept in cycle 0 => pass k dp_en in cycle 1+k*(STAGE_LAT+1); out_valid first high in cycle 1+P*(STAGE_LAT+1), P=total passes.
//  OUT: out_valid=1, held until out_ready. Handshake cycle -> IDLE; busy=0 next cycle.
//  Back-to-back: in_ready=0 outside IDLE; next frame earliest 1 cycle after out handshake.
//  flush=1: next state IDLE from any state; no dp_* pulse, out_valid, or accept in that cycle.
//  flush wins over simultaneous in_valid or out_ready. pass_cnt clears to 0.
//  Mid-frame rst: same as flush but async; frame lost.
//  Index widths: p,s < LOG2_CNT; pass_cnt saturates at P, never wraps.
// CONFIGURATION
//  SORT_DESC_CFG_EN defined: adds ports cfg_desc (in,1) and dp_desc (out,1).
//   cfg_desc is sampled on accept; dp_desc holds it until return to IDLE.
//   Datapath uses dp_desc to invert final-direction compare.
//  SORT_DESC_CFG_EN undefined: no such ports; direction fixed by datapath COM_STYLE.
// STRUCTURE
//  Shared header sort_sched_defs.vh:
//   - state encodings S_IDLE/S_ISSUE/S_WAIT/S_OUT (2-bit)
//   - localparam macro for total passes P
//  Sub-module sort_pass_idx: p/s/pass_cnt counter with clear, advance, last-pass flag.
//  FSM and wait counter stay in the top.
// TESTING (DATA_CNT=8, LOG2_CNT=3, STAGE_LAT=1, P=6)
//  Accept at cycle 0 -> dp_en in cycles 1,3,5,7,9,11 with (p,s)=(0,0),(1,1),(1,0),(2,2),(2,1),(2,0); dp_wb in cycles 2..12 even; out_valid cycle 13.
//  out_ready low 5 cycles after out_valid -> out_valid held, in_ready=0, no dp_* pulses; handshake -> in_ready=1 next cycle.
//  flush in cycle 6 -> no dp_wb at 6, IDLE at 7, pass_cnt=0, in_ready=1; new frame accepted at 7 completes normally.
//  rst pulse at cycle 4 -> all outputs 0 immediately; in_ready=1 one cycle after release.
//  STAGE_LAT=3 -> pass k dp_en at 1+4k; out_valid at cycle 25; flush and in_valid same cycle in IDLE -> no accept.
//  SORT_DESC_CFG_EN, cfg_desc=1 on accept -> dp_desc=1 through OUT; cfg_desc toggling mid-frame ignored.

Source files
------------

// File: rtl/sort_pass_sched_pkg.sv
// sort_pass_sched_pkg: shared state encoding and pass-count helper for the bitonic pass sequencer.
package sort_pass_sched_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;
  function automatic int total_passes(input int l);
    return l * (l + 1) / 2;
  endfunction
endpackage

// File: rtl/sort_pass_idx.sv
// sort_pass_idx: bitonic (phase,step) walker and saturating pass counter with clear/advance.
module sort_pass_idx
  import sort_pass_sched_pkg::*;
#(
  parameter int W      = 10,
  parameter int PHASES = 10,
  parameter int PASS_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic [W-1:0]      phase,
  output logic [W-1:0]      step,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              last
);
  localparam logic [PASS_W-1:0] P    = PASS_W'(total_passes(PHASES));
  localparam logic [W-1:0]      PMAX = W'(PHASES - 1);
  logic [W-1:0]      phase_q, phase_d, step_q, step_d;
  logic [PASS_W-1:0] cnt_q, cnt_d;
  logic              phase_end;
  assign phase_end = step_q == '0;
  always_comb begin
    phase_d = phase_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    if (clr) begin
      phase_d = '0;
      step_d  = '0;
      cnt_d   = '0;
    end else if (adv) begin
      phase_d = phase_end && phase_q != PMAX ? phase_q + 1'b1 : phase_q;
      step_d  = !phase_end ? step_q - 1'b1 : (phase_q != PMAX ? phase_q + 1'b1 : step_q);
      cnt_d   = cnt_q == P ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end
  assign phase    = phase_q;
  assign step     = step_q;
  assign pass_cnt = cnt_q;
  assign last     = phase_q == PMAX && phase_end;
endmodule

// File: rtl/sort_pass_sched.sv
// sort_pass_sched: control FSM sequencing every bitonic pass of a frame through one compare stage.
// Optional SORT_DESC_CFG_EN adds a per-frame sort-direction input latched on accept.
module sort_pass_sched
  import sort_pass_sched_pkg::*;
#(
  parameter int DATA_CNT  = 1024,
  parameter int LOG2_CNT  = 10,
  parameter int STAGE_LAT = 1,
  parameter int PASS_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SORT_DESC_CFG_EN
  input  logic                cfg_desc,
  output logic                dp_desc,
`endif
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                dp_load,
  output logic                dp_en,
  output logic                dp_wb,
  output logic [LOG2_CNT-1:0] dp_phase,
  output logic [LOG2_CNT-1:0] dp_step,
  output logic                busy,
  output logic [PASS_W-1:0]   pass_cnt
);
  localparam int         PHASES    = $clog2(DATA_CNT);
  localparam logic [3:0] WAIT_INIT = 4'(STAGE_LAT - 1);
  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       init_q, init_d;
  logic       clr, adv, last;
  sort_pass_idx #(.W(LOG2_CNT), .PHASES(PHASES), .PASS_W(PASS_W)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .adv      (adv),
    .phase    (dp_phase),
    .step     (dp_step),
    .pass_cnt (pass_cnt),
    .last     (last)
  );
  assign in_ready = state_q == S_IDLE && init_q;
  assign busy     = state_q != S_IDLE;
  assign init_d   = 1'b1;
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    dp_load   = 1'b0;
    dp_en     = 1'b0;
    dp_wb     = 1'b0;
    out_valid = 1'b0;
    clr       = 1'b0;
    adv       = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid && in_ready) begin
        dp_load = 1'b1;
        clr     = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        dp_en   = 1'b1;
        wait_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: if (wait_q == '0) begin
        dp_wb   = 1'b1;
        adv     = 1'b1;
        state_d = last ? S_OUT : S_ISSUE;
      end else wait_d = wait_q - 1'b1;
      default: begin
        out_valid = 1'b1;
        state_d   = out_ready ? S_IDLE : S_OUT;
      end
    endcase
    // abort overrides every handshake and pulse decided above
    if (flush) begin
      state_d   = S_IDLE;
      dp_load   = 1'b0;
      dp_en     = 1'b0;
      dp_wb     = 1'b0;
      out_valid = 1'b0;
      adv       = 1'b0;
      clr       = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      init_q  <= init_d;
    end
  end
`ifdef SORT_DESC_CFG_EN
  logic desc_q, desc_d;
  assign desc_d  = dp_load ? cfg_desc : (state_d == S_IDLE ? 1'b0 : desc_q);
  assign dp_desc = desc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) desc_q <= 1'b0;
    else     desc_q <= desc_d;
  end
`endif
endmodule

// File: tb/tb_sort_pass_sched.sv
// tb_sort_pass_sched: scoreboard bench driving two sequencers (STAGE_LAT 1 and 3) with directed frames.
module tb_sort_pass_sched;
  localparam int EV_LD = 0, EV_EN = 1, EV_WB = 2, EV_OUT = 3;
  localparam int BIG = 1 << 30;
  typedef struct {
    int cyc;
    int kind;
    int p;
    int s;
  } ev_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  ev_t q1[$], q3[$];
  int ps_p[6] = '{0, 1, 1, 2, 2, 2};
  int ps_s[6] = '{0, 1, 0, 2, 1, 0};
  logic rst1, flush1, in_valid1, in_ready1, out_valid1, out_ready1, dp_load1, dp_en1, dp_wb1, busy1;
  logic rst3, flush3, in_valid3, in_ready3, out_valid3, out_ready3, dp_load3, dp_en3, dp_wb3, busy3;
  logic [2:0] dp_phase1, dp_step1, dp_phase3, dp_step3;
  logic [5:0] pass_cnt1, pass_cnt3;
  logic       ovp1 = 1'b0, ovp3 = 1'b0;
`ifdef SORT_DESC_CFG_EN
  logic cfg_desc1 = 1'b0, dp_desc1, cfg_desc3 = 1'b0, dp_desc3;
`endif
  sort_pass_sched #(.DATA_CNT(8), .LOG2_CNT(3), .STAGE_LAT(1), .PASS_W(6)) u1 (
    .clk(clk), .rst(rst1),
`ifdef SORT_DESC_CFG_EN
    .cfg_desc(cfg_desc1), .dp_desc(dp_desc1),
`endif
    .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_ready(out_ready1), .dp_load(dp_load1), .dp_en(dp_en1), .dp_wb(dp_wb1),
    .dp_phase(dp_phase1), .dp_step(dp_step1), .busy(busy1), .pass_cnt(pass_cnt1)
  );
  sort_pass_sched #(.DATA_CNT(8), .LOG2_CNT(3), .STAGE_LAT(3), .PASS_W(6)) u3 (
    .clk(clk), .rst(rst3),
`ifdef SORT_DESC_CFG_EN
    .cfg_desc(cfg_desc3), .dp_desc(dp_desc3),
`endif
    .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3), .out_valid(out_valid3),
    .out_ready(out_ready3), .dp_load(dp_load3), .dp_en(dp_en3), .dp_wb(dp_wb3),
    .dp_phase(dp_phase3), .dp_step(dp_step3), .busy(busy3), .pass_cnt(pass_cnt3)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic push(input int id, input int c, input int k, input int p, input int s);
    ev_t e;
    e.cyc = c; e.kind = k; e.p = p; e.s = s;
    if (id == 1) q1.push_back(e);
    else q3.push_back(e);
  endtask
  // expected pulse schedule of one frame, truncated before cycle cut (flush/reset)
  task automatic push_frame(input int id, input int t0, input int lat, input int cut);
    if (t0 < cut) push(id, t0, EV_LD, 0, 0);
    for (int k = 0; k < 6; k++) begin
      if (t0 + 1 + k * (lat + 1) < cut) push(id, t0 + 1 + k * (lat + 1), EV_EN, ps_p[k], ps_s[k]);
      if (t0 + (k + 1) * (lat + 1) < cut) push(id, t0 + (k + 1) * (lat + 1), EV_WB, 0, 0);
    end
    if (t0 + 1 + 6 * (lat + 1) < cut) push(id, t0 + 1 + 6 * (lat + 1), EV_OUT, 0, 0);
  endtask
  task automatic observe(input int id, input int kind, input int p, input int s);
    ev_t e;
    if ((id == 1 && q1.size() == 0) || (id == 3 && q3.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_pulse dut%0d: got event kind %0d at cycle %0d, expected none", id, kind, cyc);
      return;
    end
    e = id == 1 ? q1.pop_front() : q3.pop_front();
    check($sformatf("ev_kind_dut%0d", id), kind, e.kind);
    check($sformatf("ev_cycle_dut%0d_kind%0d", id, kind), cyc, e.cyc);
    if (kind == EV_EN) begin
      check($sformatf("dp_phase_dut%0d", id), p, e.p);
      check($sformatf("dp_step_dut%0d", id), s, e.s);
    end
  endtask
  always @(negedge clk) begin
    if (!rst1) begin
      if (dp_load1) observe(1, EV_LD, 0, 0);
      if (dp_en1) observe(1, EV_EN, int'(dp_phase1), int'(dp_step1));
      if (dp_wb1) observe(1, EV_WB, 0, 0);
      if (out_valid1 && !ovp1) observe(1, EV_OUT, 0, 0);
    end
    if (!rst3) begin
      if (dp_load3) observe(3, EV_LD, 0, 0);
      if (dp_en3) observe(3, EV_EN, int'(dp_phase3), int'(dp_step3));
      if (dp_wb3) observe(3, EV_WB, 0, 0);
      if (out_valid3 && !ovp3) observe(3, EV_OUT, 0, 0);
    end
    ovp1 <= out_valid1;
    ovp3 <= out_valid3;
  end
  task automatic step_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int t0;
    rst1 = 1'b1; flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    rst3 = 1'b1; flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    step_cyc(2);
    check("rst_in_ready", in_ready1, 0);
    check("rst_busy", busy1, 0);
    check("rst_out_valid", out_valid1, 0);
    check("rst_dp_pulses", {dp_load1, dp_en1, dp_wb1}, 0);
    check("rst_index", {dp_phase1, dp_step1, pass_cnt1}, 0);
    rst1 = 1'b0; rst3 = 1'b0;
    #1 check("in_ready_before_first_edge", in_ready1, 0);
    step_cyc(1);
    check("in_ready_after_release", in_ready1, 1);
    check("in_ready_after_release_lat3", in_ready3, 1);
    t0 = cyc;
    in_valid1 = 1'b1;
`ifdef SORT_DESC_CFG_EN
    cfg_desc1 = 1'b1;
`endif
    push_frame(1, t0, 1, BIG);
    step_cyc(1);
    in_valid1 = 1'b0;
`ifdef SORT_DESC_CFG_EN
    cfg_desc1 = 1'b0;
`endif
    check("busy_after_accept", busy1, 1);
    check("in_ready_busy", in_ready1, 0);
    step_cyc(3);
`ifdef SORT_DESC_CFG_EN
    cfg_desc1 = 1'b1;
    step_cyc(1);
    cfg_desc1 = 1'b0;
`endif
    step_cyc(t0 + 13 - cyc);
    check("pass_cnt_at_out", pass_cnt1, 6);
`ifdef SORT_DESC_CFG_EN
    check("dp_desc_held", dp_desc1, 1);
`endif
    for (int i = 0; i < 5; i++) begin
      check("out_valid_held", out_valid1, 1);
      check("in_ready_in_out", in_ready1, 0);
      step_cyc(1);
    end
    check("out_valid_still_held", out_valid1, 1);
    out_ready1 = 1'b1;
    step_cyc(1);
    out_ready1 = 1'b0;
    check("out_valid_after_hs", out_valid1, 0);
    check("in_ready_after_hs", in_ready1, 1);
    check("busy_after_hs", busy1, 0);
`ifdef SORT_DESC_CFG_EN
    check("dp_desc_cleared", dp_desc1, 0);
`endif
    t0 = cyc;
    in_valid1 = 1'b1;
    push_frame(1, t0, 1, t0 + 6);
    step_cyc(1);
    in_valid1 = 1'b0;
    step_cyc(t0 + 6 - cyc);
    flush1 = 1'b1;
    check("pass_cnt_before_flush", pass_cnt1, 2);
    step_cyc(1);
    flush1 = 1'b0;
    check("flush_in_ready", in_ready1, 1);
    check("flush_pass_cnt", pass_cnt1, 0);
    check("flush_busy", busy1, 0);
    t0 = cyc;
    in_valid1 = 1'b1;
    out_ready1 = 1'b1;
    push_frame(1, t0, 1, BIG);
    step_cyc(1);
    in_valid1 = 1'b0;
    step_cyc(t0 + 13 - cyc);
    check("refill_out_valid", out_valid1, 1);
    step_cyc(1);
    out_ready1 = 1'b0;
    check("refill_in_ready", in_ready1, 1);
    t0 = cyc;
    in_valid1 = 1'b1;
    push_frame(1, t0, 1, t0 + 4);
    step_cyc(1);
    in_valid1 = 1'b0;
    step_cyc(t0 + 4 - cyc);
    rst1 = 1'b1;
    #1;
    check("midrst_busy", busy1, 0);
    check("midrst_pulses", {dp_load1, dp_en1, dp_wb1, out_valid1}, 0);
    check("midrst_index", {dp_phase1, dp_step1, pass_cnt1}, 0);
    check("midrst_in_ready", in_ready1, 0);
    step_cyc(1);
    rst1 = 1'b0;
    #1 check("midrst_release_in_ready", in_ready1, 0);
    step_cyc(1);
    check("midrst_in_ready_next", in_ready1, 1);
    t0 = cyc;
    in_valid3 = 1'b1;
    out_ready3 = 1'b1;
    push_frame(3, t0, 3, BIG);
    step_cyc(1);
    in_valid3 = 1'b0;
    step_cyc(t0 + 25 - cyc);
    check("lat3_out_valid", out_valid3, 1);
    check("lat3_pass_cnt", pass_cnt3, 6);
    step_cyc(1);
    out_ready3 = 1'b0;
    check("lat3_in_ready", in_ready3, 1);
    flush3 = 1'b1;
    in_valid3 = 1'b1;
    #1 check("flush_blocks_load", dp_load3, 0);
    step_cyc(1);
    flush3 = 1'b0;
    in_valid3 = 1'b0;
    check("flush_idle_busy", busy3, 0);
    check("flush_idle_in_ready", in_ready3, 1);
    step_cyc(3);
    check("q1_drained", q1.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
